// File: rtl/biriscv_div_sched.sv
// Shared radix-2 restoring divider with a fixed-priority two-slot scheduler.
// Slot 0 (older instruction) wins; squash aborts any in-flight or completing op.
module biriscv_div_sched #(
    parameter int unsigned FAST_SPECIAL = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [1:0]  req0_op_i,
    input  logic [31:0] req0_ra_i,
    input  logic [31:0] req0_rb_i,
    input  logic [4:0]  req0_rd_i,
    output logic        req0_accept_o,
    input  logic        req1_valid_i,
    input  logic [1:0]  req1_op_i,
    input  logic [31:0] req1_ra_i,
    input  logic [31:0] req1_rb_i,
    input  logic [4:0]  req1_rd_i,
    output logic        req1_accept_o,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        complete_o,
    output logic        complete_pipe_o,
    output logic [4:0]  complete_rd_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        pipe_q, pipe_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] div_q, div_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] result_q, result_d;
    logic        cpl_pipe_q, cpl_pipe_d;
    logic [4:0]  cpl_rd_q, cpl_rd_d;

    logic        idle_c, acc0_c, acc1_c;
    logic [1:0]  in_op;
    logic [31:0] in_ra, in_rb, a_mag, b_mag, special_res;
    logic [4:0]  in_rd;
    logic        in_signed, div_zero, ovf, special_c;
    logic [32:0] sh_rem, trial;
    logic        step_ok;
    logic [31:0] rem_nxt, quot_nxt, sel_res, fin_res;

    assign idle_c = (state_q == ST_IDLE);
    assign acc0_c = idle_c & req0_valid_i & ~flush_i;
    assign acc1_c = idle_c & req1_valid_i & ~req0_valid_i & ~flush_i;

    // Request payload of whichever slot would win arbitration
    assign in_op = req0_valid_i ? req0_op_i : req1_op_i;
    assign in_ra = req0_valid_i ? req0_ra_i : req1_ra_i;
    assign in_rb = req0_valid_i ? req0_rb_i : req1_rb_i;
    assign in_rd = req0_valid_i ? req0_rd_i : req1_rd_i;

    assign in_signed   = ~in_op[0];
    assign a_mag       = (in_signed & in_ra[31]) ? (~in_ra + 32'd1) : in_ra;
    assign b_mag       = (in_signed & in_rb[31]) ? (~in_rb + 32'd1) : in_rb;
    assign div_zero    = (in_rb == 32'd0);
    assign ovf         = in_signed & (in_ra == 32'h8000_0000) & (in_rb == 32'hFFFF_FFFF);
    assign special_c   = (FAST_SPECIAL != 0) & (div_zero | ovf);
    assign special_res = in_op[1] ? (div_zero ? in_ra : 32'd0)
                                  : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

    // One restoring step; remainder stays below the divisor so 33 bits hold the sign
    assign sh_rem   = {rem_q, quot_q[31]};
    assign trial    = sh_rem - {1'b0, div_q};
    assign step_ok  = ~trial[32];
    assign rem_nxt  = step_ok ? trial[31:0] : sh_rem[31:0];
    assign quot_nxt = {quot_q[30:0], step_ok};
    assign sel_res  = op_q[1] ? rem_nxt : quot_nxt;
    assign fin_res  = (op_q[1] ? r_neg_q : q_neg_q) ? (~sel_res + 32'd1) : sel_res;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        rd_d       = rd_q;
        pipe_d     = pipe_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_d      = div_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        result_d   = result_q;
        cpl_pipe_d = cpl_pipe_q;
        cpl_rd_d   = cpl_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (acc0_c | acc1_c) begin
                    op_d    = in_op;
                    rd_d    = in_rd;
                    pipe_d  = acc1_c;
                    // Divide-by-zero quotient is all ones regardless of dividend sign
                    q_neg_d = in_signed & (in_ra[31] ^ in_rb[31]) & ~div_zero;
                    r_neg_d = in_signed & in_ra[31];
                    div_d   = b_mag;
                    quot_d  = a_mag;
                    rem_d   = 32'd0;
                    count_d = 5'd31;
                    if (special_c) begin
                        state_d    = ST_DONE;
                        result_d   = special_res;
                        cpl_pipe_d = acc1_c;
                        cpl_rd_d   = in_rd;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rem_d   = rem_nxt;
                quot_d  = quot_nxt;
                count_d = count_q - 5'd1;
                if (count_q == 5'd0 && !flush_i) begin
                    state_d    = ST_DONE;
                    result_d   = fin_res;
                    cpl_pipe_d = pipe_q;
                    cpl_rd_d   = rd_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            count_q    <= 5'd0;
            op_q       <= 2'd0;
            rd_q       <= 5'd0;
            pipe_q     <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_q      <= 32'd0;
            rem_q      <= 32'd0;
            quot_q     <= 32'd0;
            result_q   <= 32'd0;
            cpl_pipe_q <= 1'b0;
            cpl_rd_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            pipe_q     <= pipe_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            result_q   <= result_d;
            cpl_pipe_q <= cpl_pipe_d;
            cpl_rd_q   <= cpl_rd_d;
        end
    end

    assign req0_accept_o   = acc0_c;
    assign req1_accept_o   = acc1_c;
    assign busy_o          = ~idle_c;
    assign complete_o      = (state_q == ST_DONE) & ~flush_i;
    assign complete_pipe_o = cpl_pipe_q;
    assign complete_rd_o   = cpl_rd_q;
    assign result_o        = result_q;

endmodule
